// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and the round-robin pick helper for the register-file
// writeback scheduler.
package regfile_wb_scheduler_pkg;

  localparam int REG_NUM_DEF = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // last_grant states; MEM at reset so the ALU wins the first tie
  localparam logic [0:0] LG_ALU = 1'b0;
  localparam logic [0:0] LG_MEM = 1'b1;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_NONE = 2'b00;
  localparam gnt_t GNT_ALU  = 2'b01;
  localparam gnt_t GNT_MEM  = 2'b10;

  function automatic gnt_t rr_pick(input logic [1:0] req, input logic [0:0] last);
    gnt_t gnt;
    case (req)
      2'b01:   gnt = GNT_ALU;
      2'b10:   gnt = GNT_MEM;
      2'b11:   gnt = (last == LG_MEM) ? GNT_ALU : GNT_MEM;
      default: gnt = GNT_NONE;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Handshake, writeback and scoreboard-query signals between the pipeline
// (master) and the writeback scheduler (slave).
interface regfile_wb_scheduler_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();

  logic              flush;
  logic              issue_enable;
  logic [ADDR_W-1:0] issue_rd;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;

  logic [ADDR_W-1:0] query_addr1;
  logic              query_busy1;
  logic [ADDR_W-1:0] query_addr2;
  logic              query_busy2;

  modport master (
    output flush, issue_enable, issue_rd,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    input  write_enable, write_addr, write_data,
    output query_addr1, query_addr2,
    input  query_busy1, query_busy2
  );

  modport slave (
    input  flush, issue_enable, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    output write_enable, write_addr, write_data,
    input  query_addr1, query_addr2,
    output query_busy1, query_busy2
  );

endinterface

// File: rtl/regfile_wb_scheduler_wb_rr_arbiter.sv
// Two-request round-robin arbiter (bit 0 = ALU, bit 1 = MEM) that remembers
// the last granted source and alternates on contention.
module wb_rr_arbiter
  import regfile_wb_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic [0:0] r_last_grant;
  gnt_t       w_gnt;

  // Grant selection from the current requests and the last winner
  always_comb begin
    w_gnt = rr_pick(i_req, r_last_grant);
  end

  assign o_gnt = w_gnt;

  // last_grant tracks every grant and holds when nothing is requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= LG_MEM;
    end else if (w_gnt == GNT_ALU) begin
      r_last_grant <= LG_ALU;
    end else if (w_gnt == GNT_MEM) begin
      r_last_grant <= LG_MEM;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates ALU/MEM writebacks onto the
// single write port and keeps the per-register busy scoreboard.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_scheduler_if.slave bus
);

  gnt_t              w_gnt;
  logic              w_any_grant;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;

  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [REG_NUM-1:0] r_busy;

  logic              w_busy1;
  logic              w_busy2;

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req ({bus.mem_valid, bus.alu_valid}),
    .o_gnt (w_gnt)
  );

  assign bus.alu_ready = bus.alu_valid & w_gnt[0];
  assign bus.mem_ready = bus.mem_valid & w_gnt[1];
  assign w_any_grant   = |w_gnt;

  // Route the granted source towards the commit register
  always_comb begin
    case (w_gnt)
      GNT_ALU: begin
        w_sel_rd   = bus.alu_rd;
        w_sel_data = bus.alu_data;
      end
      GNT_MEM: begin
        w_sel_rd   = bus.mem_rd;
        w_sel_data = bus.mem_data;
      end
      default: begin
        w_sel_rd   = {ADDR_W{1'b0}};
        w_sel_data = {DATA_W{1'b0}};
      end
    endcase
  end

  // Commit stage; a grant to x0 is consumed but never strobes the port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= DISABLE;
      r_waddr <= {ADDR_W{1'b0}};
      r_wdata <= {DATA_W{1'b0}};
    end else if (w_any_grant && (w_sel_rd != {ADDR_W{1'b0}})) begin
      r_we    <= ENABLE;
      r_waddr <= w_sel_rd;
      r_wdata <= w_sel_data;
    end else begin
      r_we    <= DISABLE;
      r_waddr <= r_waddr;
      r_wdata <= r_wdata;
    end
  end

  assign bus.write_enable = r_we;
  assign bus.write_addr   = r_waddr;
  assign bus.write_data   = r_wdata;

  // Scoreboard: flush beats issue, issue beats commit-clear, x0 never busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= {REG_NUM{1'b0}};
    end else if (bus.flush) begin
      r_busy <= {REG_NUM{1'b0}};
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (bus.issue_enable && (bus.issue_rd == ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (r_we && (r_waddr == ADDR_W'(i))) begin
          r_busy[i] <= 1'b0;
        end else begin
          r_busy[i] <= r_busy[i];
        end
      end
      r_busy[0] <= 1'b0;
    end
  end

  // Query port 1, hidden while its register commits (regfile bypass)
  always_comb begin
    if (r_we && (r_waddr == bus.query_addr1) &&
        !(bus.issue_enable && (bus.issue_rd == bus.query_addr1))) begin
      w_busy1 = 1'b0;
    end else begin
      w_busy1 = r_busy[bus.query_addr1];
    end
  end

  // Query port 2, same bypass rule as port 1
  always_comb begin
    if (r_we && (r_waddr == bus.query_addr2) &&
        !(bus.issue_enable && (bus.issue_rd == bus.query_addr2))) begin
      w_busy2 = 1'b0;
    end else begin
      w_busy2 = r_busy[bus.query_addr2];
    end
  end

  assign bus.query_busy1 = w_busy1;
  assign bus.query_busy2 = w_busy2;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with hand-computed expectations.
module tb_regfile_wb_scheduler;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  regfile_wb_scheduler_if #(.ADDR_W(5), .DATA_W(32)) u_if ();

  regfile_wb_scheduler #(.REG_NUM(32), .ADDR_W(5), .DATA_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  a_rd  [3];
  logic [31:0] a_dat [3];
  logic [4:0]  m_rd  [3];
  logic [31:0] m_dat [3];
  logic        exp_alu [4];
  logic [4:0]  exp_addr[4];
  logic [31:0] exp_data[4];

  initial begin
    int ai;
    int mi;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    u_if.flush = 1'b0;
    u_if.issue_enable = 1'b0;
    u_if.issue_rd = 5'd0;
    u_if.alu_valid = 1'b0;
    u_if.alu_rd = 5'd0;
    u_if.alu_data = 32'd0;
    u_if.mem_valid = 1'b0;
    u_if.mem_rd = 5'd0;
    u_if.mem_data = 32'd0;
    u_if.query_addr1 = 5'd7;
    u_if.query_addr2 = 5'd3;

    #12;
    check("rst_we",    {31'd0, u_if.write_enable}, 32'd0);
    check("rst_addr",  {27'd0, u_if.write_addr},   32'd0);
    check("rst_data",  u_if.write_data,            32'd0);
    check("rst_busy1", {31'd0, u_if.query_busy1},  32'd0);
    rst = 1'b0;
    step();

    // Contention: ALU has requests rd1/rd3, MEM has rd2/rd4
    a_rd  = '{5'd1, 5'd3, 5'd0};  a_dat = '{32'h11, 32'h33, 32'h0};
    m_rd  = '{5'd2, 5'd4, 5'd0};  m_dat = '{32'h22, 32'h44, 32'h0};
    exp_alu  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4};
    exp_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    ai = 0;
    mi = 0;
    for (int c = 0; c < 4; c++) begin
      u_if.alu_valid = (ai < 2);
      u_if.alu_rd    = a_rd[ai];
      u_if.alu_data  = a_dat[ai];
      u_if.mem_valid = (mi < 2);
      u_if.mem_rd    = m_rd[mi];
      u_if.mem_data  = m_dat[mi];
      #1;
      check($sformatf("rr_alu_rdy%0d", c), {31'd0, u_if.alu_ready}, {31'd0, exp_alu[c]});
      check($sformatf("rr_mem_rdy%0d", c), {31'd0, u_if.mem_ready}, {31'd0, ~exp_alu[c]});
      step();
      if (exp_alu[c]) ai++; else mi++;
      check($sformatf("rr_we%0d", c),   {31'd0, u_if.write_enable}, 32'd1);
      check($sformatf("rr_addr%0d", c), {27'd0, u_if.write_addr},   {27'd0, exp_addr[c]});
      check($sformatf("rr_data%0d", c), u_if.write_data,            exp_data[c]);
    end
    u_if.alu_valid = 1'b0;
    u_if.mem_valid = 1'b0;

    // Single ALU write
    u_if.alu_valid = 1'b1;
    u_if.alu_rd    = 5'd5;
    u_if.alu_data  = 32'hDEADBEEF;
    #1;
    check("alu_rdy", {31'd0, u_if.alu_ready}, 32'd1);
    check("alu_mem_rdy", {31'd0, u_if.mem_ready}, 32'd0);
    step();
    u_if.alu_valid = 1'b0;
    check("alu_we",   {31'd0, u_if.write_enable}, 32'd1);
    check("alu_addr", {27'd0, u_if.write_addr},   32'd5);
    check("alu_data", u_if.write_data,            32'hDEADBEEF);
    step();
    check("idle_we",   {31'd0, u_if.write_enable}, 32'd0);
    check("idle_addr", {27'd0, u_if.write_addr},   32'd5);

    // x0 suppression
    u_if.mem_valid = 1'b1;
    u_if.mem_rd    = 5'd0;
    u_if.mem_data  = 32'h1234;
    #1;
    check("x0_rdy", {31'd0, u_if.mem_ready}, 32'd1);
    step();
    u_if.mem_valid = 1'b0;
    check("x0_we", {31'd0, u_if.write_enable}, 32'd0);

    // Scoreboard set, commit bypass, clear
    u_if.issue_enable = 1'b1;
    u_if.issue_rd     = 5'd7;
    step();
    u_if.issue_enable = 1'b0;
    u_if.query_addr1  = 5'd7;
    u_if.query_addr2  = 5'd8;
    #1;
    check("sb_set7", {31'd0, u_if.query_busy1}, 32'd1);
    check("sb_idle8", {31'd0, u_if.query_busy2}, 32'd0);
    u_if.alu_valid = 1'b1;
    u_if.alu_rd    = 5'd7;
    u_if.alu_data  = 32'h77;
    step();
    u_if.alu_valid = 1'b0;
    #1;
    check("sb_bypass7", {31'd0, u_if.query_busy1}, 32'd0);
    step();
    check("sb_clear7", {31'd0, u_if.query_busy1}, 32'd0);

    // Issue to the register that is committing: set wins
    u_if.issue_enable = 1'b1;
    u_if.issue_rd     = 5'd7;
    step();
    u_if.issue_enable = 1'b0;
    u_if.alu_valid = 1'b1;
    u_if.alu_rd    = 5'd7;
    u_if.alu_data  = 32'h78;
    step();
    u_if.alu_valid    = 1'b0;
    u_if.issue_enable = 1'b1;
    u_if.issue_rd     = 5'd7;
    #1;
    check("sb_setclr_now", {31'd0, u_if.query_busy1}, 32'd1);
    step();
    u_if.issue_enable = 1'b0;
    #1;
    check("sb_setwins", {31'd0, u_if.query_busy1}, 32'd1);

    // Flush with a grant to rd3 in flight
    for (int k = 0; k < 3; k++) begin
      u_if.issue_enable = 1'b1;
      u_if.issue_rd     = (k == 0) ? 5'd3 : ((k == 1) ? 5'd4 : 5'd9);
      step();
    end
    u_if.issue_enable = 1'b0;
    u_if.query_addr1  = 5'd4;
    u_if.query_addr2  = 5'd9;
    #1;
    check("fl_pre4", {31'd0, u_if.query_busy1}, 32'd1);
    check("fl_pre9", {31'd0, u_if.query_busy2}, 32'd1);
    u_if.alu_valid = 1'b1;
    u_if.alu_rd    = 5'd3;
    u_if.alu_data  = 32'h3333;
    u_if.flush     = 1'b1;
    step();
    u_if.alu_valid = 1'b0;
    u_if.flush     = 1'b0;
    check("fl_we",   {31'd0, u_if.write_enable}, 32'd1);
    check("fl_addr", {27'd0, u_if.write_addr},   32'd3);
    check("fl_data", u_if.write_data,            32'h3333);
    check("fl_busy4", {31'd0, u_if.query_busy1}, 32'd0);
    check("fl_busy9", {31'd0, u_if.query_busy2}, 32'd0);
    u_if.query_addr1 = 5'd7;
    u_if.query_addr2 = 5'd3;
    #1;
    check("fl_busy7", {31'd0, u_if.query_busy1}, 32'd0);
    step();
    check("fl_busy3", {31'd0, u_if.query_busy2}, 32'd0);

    // Async reset while a write is on the port; last grant was ALU
    u_if.alu_valid    = 1'b1;
    u_if.alu_rd       = 5'd10;
    u_if.alu_data     = 32'hAAAA;
    u_if.issue_enable = 1'b1;
    u_if.issue_rd     = 5'd12;
    step();
    u_if.alu_valid    = 1'b0;
    u_if.issue_enable = 1'b0;
    u_if.query_addr1  = 5'd12;
    #1;
    check("ar_pre_we",   {31'd0, u_if.write_enable}, 32'd1);
    check("ar_pre_busy", {31'd0, u_if.query_busy1},  32'd1);
    rst = 1'b1;
    #1;
    check("ar_we",   {31'd0, u_if.write_enable}, 32'd0);
    check("ar_addr", {27'd0, u_if.write_addr},   32'd0);
    check("ar_busy", {31'd0, u_if.query_busy1},  32'd0);
    rst = 1'b0;
    u_if.alu_valid = 1'b1;
    u_if.alu_rd    = 5'd1;
    u_if.alu_data  = 32'h1;
    u_if.mem_valid = 1'b1;
    u_if.mem_rd    = 5'd2;
    u_if.mem_data  = 32'h2;
    #1;
    check("ar_tie_alu", {31'd0, u_if.alu_ready}, 32'd1);
    check("ar_tie_mem", {31'd0, u_if.mem_ready}, 32'd0);
    step();
    u_if.alu_valid = 1'b0;
    u_if.mem_valid = 1'b0;
    check("ar_commit", {27'd0, u_if.write_addr}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules the register file's single write port between two writeback sources: the ALU path and the load/store (MEM) path.
- Keeps a per-register busy scoreboard. Issue logic uses it to stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file. It drives write_enable/write_addr/write_data and exposes busy status for the two read ports.

Parameters:
- REG_NUM, 32, number of architectural registers.
- ADDR_W, 5, register address width (log2 REG_NUM).
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush; clears the scoreboard
- issue_enable  in  1  an instruction with a destination register is issued this cycle
- issue_rd  in  ADDR_W  destination of the issued instruction
- alu_valid  in  1  ALU writeback request
- alu_rd  in  ADDR_W  ALU destination
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  MEM writeback request
- mem_rd  in  ADDR_W  MEM destination
- mem_data  in  DATA_W  load result
- mem_ready  out  1  MEM request accepted this cycle
- write_enable  out  1  register file write strobe
- write_addr  out  ADDR_W  register file write address
- write_data  out  DATA_W  register file write data
- query_addr1  in  ADDR_W  read port 1 address to check
- query_busy1  out  1  query_addr1 has a pending write
- query_addr2  in  ADDR_W  read port 2 address to check
- query_busy2  out  1  query_addr2 has a pending write

Behaviour:
- Reset (async, rst=1): write_enable=0, write_addr=0, write_data=0, busy table all 0, last_grant=MEM (so ALU wins the first tie).
- Reset mid-transfer drops any accepted-but-uncommitted write.
- Arbitration (combinational, per cycle):
  - Only one source valid: that source is granted.
  - Both valid: round-robin. Grant the source not in last_grant; update last_grant on every grant.
  - Neither valid: no grant; last_grant is held.
- Ready rule: alu_ready = alu_valid & grant_alu; mem_ready = mem_valid & grant_mem. Never both ready in one cycle.
- A source must hold valid/rd/data stable until its ready is seen. The ungranted source waits.
- Commit pipeline: one output register stage. A grant in cycle N produces write_enable=1 with the granted rd/data in cycle N+1. Throughput is one write per cycle. The register file never backpressures.
- With no grant in cycle N, write_enable=0 in N+1. write_addr/write_data hold their previous values.
- rd==0: the request is accepted (ready=1) but write_enable stays 0 in N+1. x0 is never written.
- Scoreboard:
  - busy[r] is set at posedge when issue_enable=1 and issue_rd=r, r!=0.
  - busy[r] is cleared at posedge when the committed write (write_enable=1, write_addr=r) is on the port.
  - Simultaneous set and clear of the same r: set wins. A new producer supersedes the old one.
  - busy[0] is constant 0.
- Query: query_busyK = busy[query_addrK], combinational. Exception: 0 when write_enable=1 and write_addr==query_addrK and there is no same-cycle set. This matches the register file's write-to-read bypass, so a reader sees the committing value without an extra stall.
- flush=1: busy table cleared at posedge. Takes priority over a same-cycle issue set. An already-granted write still commits in the next cycle. Sources may keep requesting during flush; arbitration is unaffected.
- No internal width growth. Addresses compare on ADDR_W bits; data passes through unmodified.

Decomposition:
- The shared config.v include supplies Zero, ZeroReg, RegAddrBus/RegBus widths and Enable/Disable constants.
- Add a 2-way round-robin arbiter macro pair to config.v if one does not already exist.
- One natural sub-module: wb_rr_arbiter, a two-request round-robin with last_grant state and a grant vector out. The scoreboard and output stage stay in the top.

Test Plan:
- Single ALU write: alu_valid=1, rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle write_enable=1, write_addr=5, write_data=0xDEADBEEF.
- Contention: both valid for 4 cycles (ALU rd=1, MEM rd=2), each deasserting after its ready -> grants alternate ALU, MEM; ALU goes first after reset; commits follow one cycle later in the same order.
- x0 suppression: mem_valid=1, rd=0, data=0x1234 -> mem_ready=1; write_enable=0 next cycle.
- Scoreboard:
  - issue rd=7 -> query_busy1(7)=1 next cycle.
  - ALU commits rd=7 -> query_busy1=0 during the commit cycle; busy[7] is clear afterwards.
  - Issue rd=7 in the same cycle as that commit -> busy[7] stays 1.
- Flush: busy set on regs 3, 4, 9; flush=1 while a grant to rd=3 is in flight -> all busy bits clear; the rd=3 write still commits next cycle.
- Async reset mid-operation: assert rst between clock edges while write_enable=1 -> write_enable drops to 0 immediately, busy table clears, first post-reset tie goes to ALU.
